phy_link: RTL and testbench
===========================

PHY_LINK -- requirements
Module: phy_link

Interface
REQ-001 SHALL provide parameter FLIT_W, default 18: flit width; MSB is the flit-valid bit.
REQ-002 SHALL provide parameter LANE_W, default 8: serial lane width; BEATS = ceil(FLIT_W/LANE_W), derived (3 by default).
REQ-003 SHALL provide parameter DEPTH, default 32, power of 2: TX FIFO depth in flits.
REQ-004 SHALL provide parameter HALF, default 2: CLK cycles per strobe phase (2..15).
REQ-005 SHALL have ports: CLK in 1, clock; rst_n in 1, reset, synchronous, active-low; clock CLK.
REQ-006 SHALL have ports: tx_flit in FLIT_W; tx_valid in 1; tx_ready out 1 (FIFO not full).
REQ-007 SHALL have ports: link_clk_out out 1 (forwarded strobe); link_data_out out LANE_W; link_par_out out 1.
REQ-008 SHALL have ports: link_clk_in in 1; link_data_in in LANE_W; link_par_in in 1 (all asynchronous to CLK).
REQ-009 SHALL have ports: rx_flit out FLIT_W; rx_valid out 1; rx_ready in 1.
REQ-010 SHALL have ports: tx_level out log2(DEPTH)+1 (FIFO occupancy); rx_drop out 1 (sticky overrun flag); par_err_cnt out 8.

Function
REQ-011 SHALL write tx_flit into the TX FIFO on an edge with tx_valid & tx_ready & tx_flit[MSB]; flits with MSB=0 are discarded.
REQ-012 SHALL derive tx_ready from registered occupancy; a push while full is not accepted, even if a pop occurs in the same cycle.
REQ-013 SHALL run the TX FSM with states IDLE, BEAT, GAP; IDLE->BEAT when the FIFO is non-empty, popping one flit.
REQ-014 SHALL drive each beat for 2*HALF cycles: link_clk_out low for HALF cycles, then high for HALF cycles; data is stable for the whole beat.
REQ-015 SHALL send beats MSB-first, with the first beat zero-padded in its upper bits; after the last beat, GAP drives zero data for one beat, then returns to IDLE.
REQ-016 SHALL register the first beat on link_data_out at the second rising edge after the write edge, when the FIFO is empty and the FSM is in IDLE.
REQ-017 SHALL pass link_clk_in, link_data_in and link_par_in through a 2-flop synchroniser and sample data on the detected rising edge of the strobe.
REQ-018 SHALL start an RX frame only on a beat whose valid-bit position is 1; other beats while idle are ignored.
REQ-019 SHALL assemble BEATS beats, then load rx_flit and assert rx_valid on the cycle after the final edge is detected.
REQ-020 SHALL hold rx_flit and rx_valid until rx_valid & rx_ready; a new frame completing while rx_valid & !rx_ready is dropped and sets rx_drop.
REQ-021 SHALL clear rx_drop only on reset.

Reset
REQ-022 SHALL, on rst_n=0 at an edge, set tx_ready=0, link_clk_out=0, link_data_out=0, link_par_out=0, rx_valid=0, rx_flit=0, tx_level=0, rx_drop=0, par_err_cnt=0.
REQ-023 SHALL empty the FIFO, return both FSMs to idle, abort any in-progress TX or RX frame, and raise tx_ready on the first cycle after reset is released.

Configuration
REQ-024 SHALL, with PHY_LINK_PARITY_EN defined, drive link_par_out as the XOR of link_data_out for every beat, including GAP.
REQ-025 SHALL, with PHY_LINK_PARITY_EN defined, check parity on every received beat; a frame with any mismatched beat is discarded and par_err_cnt increments, saturating at 255.
REQ-026 SHALL, without PHY_LINK_PARITY_EN, hold link_par_out=0 and par_err_cnt=0 and ignore link_par_in.

Verification
REQ-027 SHALL cover TX serialise, defaults: push 18'h2A5C3 -> link_data_out 0x02, 0xA5, 0xC3, 0x00, each held 4 cycles, with link_clk_out 0,0,1,1 per beat.
REQ-028 SHALL cover loopback (out tied to in): push 18'h3FFFF, 18'h20001 -> rx_flit 18'h3FFFF then 18'h20001 in order; rx_drop=0.
REQ-029 SHALL cover full/invalid input: push 33 flits with the link stalled -> tx_ready=0 after 32, tx_level=32; the 33rd is lost; a push of 18'h0FFFF is never serialised.
REQ-030 SHALL cover overrun: in loopback with rx_ready=0, send 2 flits -> first held on rx_flit, second dropped, rx_drop=1.
REQ-031 SHALL cover parity (macro on): flip link_par_in on the second beat of 18'h2A5C3 -> no rx_valid, par_err_cnt=1.
REQ-032 SHALL cover reset mid-frame: assert rst_n=0 during the second beat -> all outputs at reset values next edge; the next clean frame is received correctly.

Source files
------------

// File: rtl/phy_link.sv
// phy_link: FIFO-backed flit serialiser with a forwarded strobe, plus a synchronised deserialiser.
// Define PHY_LINK_PARITY_EN to add per-beat parity generation and checking.
module phy_link #(
   parameter int unsigned FLIT_W = 18,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned HALF   = 2
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic [FLIT_W-1:0]      tx_flit,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   link_clk_out,
   output logic [LANE_W-1:0]      link_data_out,
   output logic                   link_par_out,
   input  logic                   link_clk_in,
   input  logic [LANE_W-1:0]      link_data_in,
   input  logic                   link_par_in,
   output logic [FLIT_W-1:0]      rx_flit,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic                   rx_drop,
   output logic [7:0]             par_err_cnt
);
   localparam int unsigned BEATS = (FLIT_W + LANE_W - 1) / LANE_W;
   localparam int unsigned PAD_W = BEATS * LANE_W;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;
   localparam int unsigned PH_W  = $clog2(2 * HALF);
   localparam int unsigned BT_W  = $clog2(BEATS + 1);
   localparam int unsigned VPOS  = FLIT_W - 1 - (BEATS - 1) * LANE_W;

   typedef enum logic [1:0] {TX_IDLE, TX_BEAT, TX_GAP} tx_st_t;

   logic [FLIT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [LVL_W-1:0]  r_level;
   logic [LVL_W-1:0]  w_level_nxt;
   logic              r_tx_ready;
   logic              w_push, w_pop;

   tx_st_t            r_tx_st;
   logic [PH_W-1:0]   r_phase;
   logic [BT_W-1:0]   r_beat;
   logic [PAD_W-1:0]  r_tx_sh;
   logic              r_clk_out, r_par_out;
   logic [LANE_W-1:0] r_data_out;
   logic              w_ph_end, w_strobe, w_par;
   logic [LANE_W-1:0] w_lane;

   logic              r_ck_s1, r_ck_s2, r_ck_s3;
   logic [LANE_W-1:0] r_d_s1, r_d_s2;
   logic              w_rise, w_mis, w_take, w_last, w_perr;
   logic              r_rx_busy, r_rx_perr;
   logic [BT_W-1:0]   r_rx_cnt;
   logic [BT_W-1:0]   w_cnt;
   logic [PAD_W-1:0]  r_rx_sh;
   logic [PAD_W-1:0]  w_rx_full;
   logic [FLIT_W-1:0] r_rx_flit;
   logic              r_rx_valid, r_rx_drop;
   logic [7:0]        r_perr_cnt;
   logic              w_unused_rx;

   // TX FIFO: only flits carrying the valid bit are stored
   assign w_push = tx_valid & r_tx_ready & tx_flit[FLIT_W-1];
   assign w_pop  = (r_tx_st == TX_IDLE) && (r_level != '0);

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop)
         w_level_nxt = r_level + LVL_W'(1);
      else if (!w_push && w_pop)
         w_level_nxt = r_level - LVL_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem[r_wptr] <= tx_flit;
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_tx_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_level    <= w_level_nxt;
         r_tx_ready <= (w_level_nxt != LVL_W'(DEPTH));
      end
   end

   // Link pins are registered one cycle behind the FSM state that produces them
   assign w_ph_end = (r_phase == PH_W'(2 * HALF - 1));
   assign w_lane   = (r_tx_st == TX_BEAT) ? r_tx_sh[PAD_W-1 -: LANE_W] : '0;
   assign w_strobe = (r_tx_st != TX_IDLE) && (r_phase >= PH_W'(HALF));

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_tx_st    <= TX_IDLE;
         r_phase    <= '0;
         r_beat     <= '0;
         r_tx_sh    <= '0;
         r_clk_out  <= 1'b0;
         r_data_out <= '0;
         r_par_out  <= 1'b0;
      end else begin
         r_clk_out  <= w_strobe;
         r_data_out <= w_lane;
         r_par_out  <= w_par;
         case (r_tx_st)
            TX_IDLE: begin
               if (w_pop) begin
                  r_tx_st <= TX_BEAT;
                  r_phase <= '0;
                  r_beat  <= '0;
                  r_tx_sh <= PAD_W'(r_mem[r_rptr]);
               end
            end
            TX_BEAT: begin
               if (w_ph_end) begin
                  r_phase <= '0;
                  r_tx_sh <= r_tx_sh << LANE_W;
                  if (r_beat == BT_W'(BEATS - 1))
                     r_tx_st <= TX_GAP;
                  else
                     r_beat <= r_beat + BT_W'(1);
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            TX_GAP: begin
               if (w_ph_end) begin
                  r_tx_st <= TX_IDLE;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            default: r_tx_st <= TX_IDLE;
         endcase
      end
   end

   // Two-flop synchronisers; the third strobe flop provides rising-edge detection
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_ck_s1 <= 1'b0;
         r_ck_s2 <= 1'b0;
         r_ck_s3 <= 1'b0;
         r_d_s1  <= '0;
         r_d_s2  <= '0;
      end else begin
         r_ck_s1 <= link_clk_in;
         r_ck_s2 <= r_ck_s1;
         r_ck_s3 <= r_ck_s2;
         r_d_s1  <= link_data_in;
         r_d_s2  <= r_d_s1;
      end
   end

`ifdef PHY_LINK_PARITY_EN
   logic r_p_s1, r_p_s2;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_p_s1 <= 1'b0;
         r_p_s2 <= 1'b0;
      end else begin
         r_p_s1 <= link_par_in;
         r_p_s2 <= r_p_s1;
      end
   end

   assign w_mis = (^r_d_s2) ^ r_p_s2;
   assign w_par = ^w_lane;
`else
   logic w_unused_par;
   assign w_unused_par = link_par_in;
   assign w_mis        = 1'b0;
   assign w_par        = 1'b0;
`endif

   // A frame opens only on a beat whose valid-bit position is set
   assign w_rise      = r_ck_s2 & ~r_ck_s3;
   assign w_take      = w_rise & (r_rx_busy | r_d_s2[VPOS]);
   assign w_cnt       = r_rx_busy ? r_rx_cnt : '0;
   assign w_last      = w_take && (w_cnt == BT_W'(BEATS - 1));
   assign w_perr      = (r_rx_busy & r_rx_perr) | w_mis;
   assign w_rx_full   = (r_rx_sh << LANE_W) | PAD_W'(r_d_s2);
   assign w_unused_rx = ^w_rx_full;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_rx_busy  <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_cnt   <= '0;
         r_rx_sh    <= '0;
         r_rx_flit  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_drop  <= 1'b0;
         r_perr_cnt <= '0;
      end else begin
         if (w_take) begin
            r_rx_sh   <= w_rx_full;
            r_rx_perr <= w_perr;
            r_rx_cnt  <= w_cnt + BT_W'(1);
            r_rx_busy <= !w_last;
         end
         if (w_last && !w_perr) begin
            if (r_rx_valid && !rx_ready) begin
               r_rx_drop <= 1'b1;
            end else begin
               r_rx_valid <= 1'b1;
               r_rx_flit  <= w_rx_full[FLIT_W-1:0];
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_last && w_perr && (r_perr_cnt != 8'hFF))
            r_perr_cnt <= r_perr_cnt + 8'd1;
      end
   end

   assign tx_ready      = r_tx_ready;
   assign tx_level      = r_level;
   assign link_clk_out  = r_clk_out;
   assign link_data_out = r_data_out;
   assign link_par_out  = r_par_out;
   assign rx_flit       = r_rx_flit;
   assign rx_valid      = r_rx_valid;
   assign rx_drop       = r_rx_drop;
   assign par_err_cnt   = r_perr_cnt;

endmodule

// File: tb/tb_phy_link.sv
// tb_phy_link: transaction-level model of phy_link checked every cycle, plus literal pins for key scenarios.
`timescale 1ns/1ps
module tb_phy_link;
   localparam int FLIT_W = 18;
   localparam int LANE_W = 8;
   localparam int DEPTH  = 32;
   localparam int HALF   = 2;
   localparam int BEATS  = 3;
   localparam int PAD_W  = BEATS * LANE_W;
   localparam int FRAME  = (BEATS + 1) * 2 * HALF;
   localparam int RX_LAT = (BEATS - 1) * 2 * HALF + HALF + 4;
`ifdef PHY_LINK_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              rst_n = 1'b0;
   logic [FLIT_W-1:0] tx_flit = '0;
   logic              tx_valid = 1'b0;
   logic              rx_ready = 1'b1;
   logic              lb = 1'b0;
   logic              pflip = 1'b0;
   logic              tx_ready, link_clk_out, link_par_out;
   logic [LANE_W-1:0] link_data_out;
   logic              link_clk_in, link_par_in;
   logic [LANE_W-1:0] link_data_in;
   logic [FLIT_W-1:0] rx_flit;
   logic              rx_valid, rx_drop;
   logic [5:0]        tx_level;
   logic [7:0]        par_err_cnt;

   assign link_clk_in  = lb & link_clk_out;
   assign link_data_in = lb ? link_data_out : '0;
   assign link_par_in  = lb & (link_par_out ^ pflip);

   phy_link dut (
      .CLK(CLK), .rst_n(rst_n),
      .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .link_clk_out(link_clk_out), .link_data_out(link_data_out), .link_par_out(link_par_out),
      .link_clk_in(link_clk_in), .link_data_in(link_data_in), .link_par_in(link_par_in),
      .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_level(tx_level), .rx_drop(rx_drop), .par_err_cnt(par_err_cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;
   bit inj = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model state
   typedef struct {int due; logic [FLIT_W-1:0] f; bit bad;} arr_t;
   logic [FLIT_W-1:0] flit_q [$];
   logic [8:0]        pat_q [$];
   arr_t              arr_q [$];
   int                edge_n = 0;
   int                tx_busy = 0;
   bit                m_ready = 0, m_clk = 0, m_par = 0, m_rv = 0, m_drop = 0;
   logic [LANE_W-1:0] m_data = '0;
   logic [FLIT_W-1:0] m_flit = '0;
   int                m_perr = 0;
   logic [8:0]        pe;
   logic [FLIT_W-1:0] pf;
   logic [PAD_W-1:0]  pad;
   arr_t              a;
   bit                arrival, ok_arr;

   always @(posedge CLK) begin
      edge_n++;
      if (!rst_n) begin
         flit_q.delete(); pat_q.delete(); arr_q.delete();
         tx_busy = 0; m_ready = 0; m_clk = 0; m_data = '0; m_par = 0;
         m_rv = 0; m_flit = '0; m_drop = 0; m_perr = 0;
      end else begin
         if (pat_q.size() > 0) begin
            pe = pat_q.pop_front();
            m_clk = pe[8]; m_data = pe[7:0];
         end else begin
            m_clk = 0; m_data = '0;
         end
         m_par = PAR & (^m_data);
         arrival = (arr_q.size() > 0) && (arr_q[0].due == edge_n);
         if (arrival) a = arr_q.pop_front();
         ok_arr = arrival && !(PAR && a.bad);
         if (arrival && !ok_arr && m_perr < 255) m_perr++;
         if (ok_arr && m_rv && !rx_ready) m_drop = 1;
         else if (ok_arr) begin m_rv = 1; m_flit = a.f; end
         else if (m_rv && rx_ready) m_rv = 0;
         if (tx_busy == 0 && flit_q.size() > 0) begin
            pf = flit_q.pop_front();
            pad = PAD_W'(pf);
            for (int b = 0; b < BEATS; b++)
               for (int p = 0; p < 2 * HALF; p++)
                  pat_q.push_back({1'(p >= HALF), pad[PAD_W-1-b*LANE_W -: LANE_W]});
            for (int p = 0; p < 2 * HALF; p++)
               pat_q.push_back({1'(p >= HALF), 8'h00});
            tx_busy = FRAME;
            if (lb) arr_q.push_back('{edge_n + RX_LAT, pf, inj});
         end else if (tx_busy > 0) begin
            tx_busy--;
         end
         if (tx_valid && m_ready && tx_flit[FLIT_W-1]) flit_q.push_back(tx_flit);
         m_ready = (flit_q.size() != DEPTH);
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         check("tx_ready", tx_ready, m_ready);
         check("tx_level", tx_level, flit_q.size());
         check("link_clk_out", link_clk_out, m_clk);
         check("link_data_out", link_data_out, m_data);
         check("link_par_out", link_par_out, m_par);
         check("rx_valid", rx_valid, m_rv);
         check("rx_flit", rx_flit, m_flit);
         check("rx_drop", rx_drop, m_drop);
         check("par_err_cnt", par_err_cnt, m_perr);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push(input logic [FLIT_W-1:0] f);
      @(negedge CLK);
      tx_flit = f; tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input logic [FLIT_W-1:0] exp, input string nm);
      int n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check({nm, "_valid"}, rx_valid, 1);
      check(nm, rx_flit, exp);
      @(negedge CLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_b [4];
      int n;
      exp_b[0] = 8'h02; exp_b[1] = 8'hA5; exp_b[2] = 8'hC3; exp_b[3] = 8'h00;

      // Reset values
      @(posedge CLK);
      cmp_en = 1'b1;
      tick(3);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_link", {link_clk_out, link_data_out, link_par_out}, 0);
      check("rst_rx", {rx_valid, rx_flit, rx_drop}, 0);
      check("rst_level", tx_level, 0);
      check("rst_perr", par_err_cnt, 0);
      rst_n = 1'b1;
      tick(1);
      check("tx_ready_after_rst", tx_ready, 1);

      // Serialise 18'h2A5C3 with link open
      lb = 1'b0;
      push(18'h2A5C3);
      tick(1);
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         check("ser_data", link_data_out, exp_b[i/4]);
         check("ser_clk", link_clk_out, 32'((i % 4) >= 2));
      end
      tick(5);

      // Loopback, two back-to-back flits
      lb = 1'b1; rx_ready = 1'b1;
      push(18'h3FFFF);
      push(18'h20001);
      wait_rx(18'h3FFFF, "lb_first");
      wait_rx(18'h20001, "lb_second");
      check("lb_drop", rx_drop, 0);
      tick(20);

      // Overrun with rx_ready low
      rx_ready = 1'b0;
      push(18'h21111);
      push(18'h32222);
      tick(60);
      check("ovr_valid", rx_valid, 1);
      check("ovr_flit", rx_flit, 18'h21111);
      check("ovr_drop", rx_drop, 1);
      rx_ready = 1'b1;
      tick(2);
      check("ovr_consumed", rx_valid, 0);
      tick(10);

      // Fill FIFO to full, offer one more, then an invalid flit
      lb = 1'b0;
      n = 0;
      @(negedge CLK);
      while (tx_ready && n < 100) begin
         tx_flit = 18'(32'h20000 | n); tx_valid = 1'b1;
         n++;
         @(negedge CLK);
      end
      check("full_ready", tx_ready, 0);
      check("full_level", tx_level, 32);
      tx_flit = 18'h3ABCD;
      @(negedge CLK);
      tx_valid = 1'b0;
      n = 0;
      while (tx_level != 0 && n < 800) begin
         @(negedge CLK);
         n++;
      end
      check("drain_level", tx_level, 0);
      tick(20);
      push(18'h0FFFF);
      tick(3);
      check("invalid_level", tx_level, 0);
      tick(20);
      check("invalid_data", link_data_out, 0);

`ifdef PHY_LINK_PARITY_EN
      // Corrupt parity on the second beat
      lb = 1'b1; rx_ready = 1'b1; inj = 1'b1;
      push(18'h2A5C3);
      tick(1);
      inj = 1'b0;
      tick(5);
      pflip = 1'b1;
      tick(3);
      pflip = 1'b0;
      tick(40);
      check("par_no_valid", rx_valid, 0);
      check("par_cnt", par_err_cnt, 1);
      push(18'h2A5C3);
      wait_rx(18'h2A5C3, "par_clean");
      tick(10);
`endif

      // Reset during the second beat, then a clean frame
      lb = 1'b1; rx_ready = 1'b1;
      push(18'h2A5C3);
      tick(7);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_link", {link_clk_out, link_data_out, link_par_out}, 0);
      check("mid_rst_rx", {rx_valid, rx_flit, rx_drop}, 0);
      check("mid_rst_tx", {tx_ready, tx_level, par_err_cnt}, 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      push(18'h2A5C3);
      wait_rx(18'h2A5C3, "post_rst");
      check("post_rst_drop", rx_drop, 0);
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
